// File: rtl/humidity_pkg.sv
// Shared types and constants for the humidity frame decoder.
// Holds the FSM encoding, frame byte-lane indices and the double-dabble step.
`timescale 1ns/1ps
package humidity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_CONV,
    ST_DONE
  } state_t;

  localparam int unsigned B_HUM_INT  = 4;
  localparam int unsigned B_HUM_DEC  = 3;
  localparam int unsigned B_TEMP_INT = 2;
  localparam int unsigned B_TEMP_DEC = 1;
  localparam int unsigned B_SUM      = 0;

  localparam logic [2:0] MSTATE_DONE = 3'd3;

  localparam int unsigned BCD_W = 12;
  localparam int unsigned DD_W  = BCD_W + 8;

  function automatic logic [7:0] lane(input logic [39:0] frame, input int unsigned idx);
    return frame[8*idx +: 8];
  endfunction

  // One add-3-then-shift iteration over {hundreds,tens,units,binary}.
  function automatic logic [DD_W-1:0] dabble_step(input logic [DD_W-1:0] s);
    logic [DD_W-1:0] t;
    t = s;
    for (int unsigned d = 0; d < 3; d++) begin
      if (t[8+4*d +: 4] >= 4'd5)
        t[8+4*d +: 4] = t[8+4*d +: 4] + 4'd3;
    end
    return {t[DD_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/humidity_decoder_if.sv
// Reader-to-decoder frame bus: 40-bit frame plus reader state.
`timescale 1ns/1ps
interface humidity_decoder_if;
  logic [39:0] hym;
  logic [2:0]  mstate;

  modport master (output hym, output mstate);
  modport slave  (input hym, input mstate);
endinterface

// File: rtl/bin2bcd8.sv
// Sequential 8-bit to 3-digit BCD converter: start, eight iterations, done.
`timescale 1ns/1ps
module bin2bcd8
  import humidity_pkg::*;
(
  input  logic             clk1M,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  logic [DD_W-1:0] sr;
  logic [DD_W-1:0] sr_nxt;
  logic [2:0]      cnt;
  logic            run;

  always_comb sr_nxt = dabble_step(sr);

  always_ff @(posedge clk1M or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      sr  <= {{BCD_W{1'b0}}, bin};
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      sr  <= sr_nxt;
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) run <= 1'b0;
    end
  end

  // The result is taken from the final iteration's next value so the consumer
  // can load it on the same edge the eighth iteration completes.
  always_comb begin
    done = run && (cnt == 3'd7);
    bcd  = sr_nxt[DD_W-1 -: BCD_W];
  end

endmodule

// File: rtl/humidity_decoder.sv
// Checks DHT frames, converts humidity/temperature to BCD, drives fan and fault flags.
// Build option: define HUM_FAN_HYST_EN for a hysteresis band on fan switch-off.
`timescale 1ns/1ps
module humidity_decoder
  import humidity_pkg::*;
#(
  parameter logic [7:0]  HUM_ON   = 8'd70,
  parameter logic [7:0]  HUM_HYST = 8'd5,
  parameter int unsigned MISS_MAX = 3
) (
  input  logic                     clk1M,
  input  logic                     rst,
  humidity_decoder_if.slave        rd,
  input  logic                     flag_five_sec,
  output logic [7:0]               hum_int,
  output logic [7:0]               temp_int,
  output logic [BCD_W-1:0]         hum_bcd,
  output logic [BCD_W-1:0]         temp_bcd,
  output logic                     sample_stb,
  output logic                     crc_err,
  output logic [7:0]               err_cnt,
  output logic                     sensor_fault,
  output logic                     fan_on,
  output logic                     busy
);

`ifdef HUM_FAN_HYST_EN
  localparam bit HYST_EN = 1'b1;
`else
  localparam bit HYST_EN = 1'b0;
`endif
  localparam logic [7:0] HUM_OFF  = HYST_EN ? (HUM_ON - HUM_HYST) : HUM_ON;
  localparam logic [7:0] MISS_LIM = 8'(MISS_MAX);

  state_t          state_q, state_d;
  logic [2:0]      mstate_q;
  logic            flag_q;
  logic [39:0]     frame;
  logic [7:0]      sum;
  logic [7:0]      miss_cnt;
  logic            fan_q;
  logic            trig, good, conv_start, load;
  logic            hum_done, temp_done;
  logic [BCD_W-1:0] hum_bcd_nxt, temp_bcd_nxt;

  always_comb begin
    trig = (rd.mstate == MSTATE_DONE) && (mstate_q != MSTATE_DONE);
    sum  = lane(frame, B_HUM_INT) + lane(frame, B_HUM_DEC)
         + lane(frame, B_TEMP_INT) + lane(frame, B_TEMP_DEC);
    good = (sum == lane(frame, B_SUM)) && (frame != '0);
    load = (state_q == ST_CONV) && hum_done && temp_done;
  end

  always_ff @(posedge clk1M or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (trig) state_d = ST_CHECK;
      ST_CHECK: state_d = good ? ST_CONV : ST_IDLE;
      ST_CONV:  if (load) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    sample_stb = (state_q == ST_DONE);
    crc_err    = (state_q == ST_CHECK) && !good;
    conv_start = (state_q == ST_CHECK) && good;
  end

  bin2bcd8 u_hum_bcd (
    .clk1M (clk1M),
    .rst   (rst),
    .start (conv_start),
    .bin   (lane(frame, B_HUM_INT)),
    .bcd   (hum_bcd_nxt),
    .done  (hum_done)
  );

  bin2bcd8 u_temp_bcd (
    .clk1M (clk1M),
    .rst   (rst),
    .start (conv_start),
    .bin   (lane(frame, B_TEMP_INT)),
    .bcd   (temp_bcd_nxt),
    .done  (temp_done)
  );

  always_ff @(posedge clk1M or posedge rst) begin
    if (rst) begin
      mstate_q <= '0;
      flag_q   <= 1'b0;
      frame    <= '0;
      err_cnt  <= '0;
      miss_cnt <= '0;
      hum_int  <= '0;
      temp_int <= '0;
      hum_bcd  <= '0;
      temp_bcd <= '0;
      fan_q    <= 1'b0;
    end else begin
      mstate_q <= rd.mstate;
      flag_q   <= flag_five_sec;
      if (state_q == ST_IDLE && trig) frame <= rd.hym;
      if (crc_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      // Outputs load on the edge entering DONE so they are valid alongside sample_stb.
      if (load) begin
        hum_int  <= lane(frame, B_HUM_INT);
        temp_int <= lane(frame, B_TEMP_INT);
        hum_bcd  <= hum_bcd_nxt;
        temp_bcd <= temp_bcd_nxt;
        if (lane(frame, B_HUM_INT) >= HUM_ON)      fan_q <= 1'b1;
        else if (lane(frame, B_HUM_INT) < HUM_OFF) fan_q <= 1'b0;
      end
      // A good frame clears the stale count and takes priority over a strobe edge.
      if (load || state_q == ST_DONE)
        miss_cnt <= '0;
      else if (flag_five_sec && !flag_q && miss_cnt != MISS_LIM)
        miss_cnt <= miss_cnt + 8'd1;
    end
  end

  always_comb begin
    sensor_fault = (miss_cnt == MISS_LIM);
    fan_on       = fan_q && !sensor_fault;
  end

endmodule
